lcd_in_pio: RTL

LCD_IN_PIO -- requirements
Module: lcd_in_pio

---
 rtl/lcd_in_pio.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lcd_in_pio.sv
// Avalon-MM input PIO for LCD status/data lines: synchronizes, debounces and
// edge-captures in_port, with an irq mask and a level interrupt.
module lcd_in_pio #(
  parameter int WIDTH     = 8,
  parameter int DEBOUNCE  = 4,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);

  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] readdata_q, readdata_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [1:0]       prime_cnt_q, prime_cnt_d;
  logic             primed_q, primed_d;
  logic             irq_q, irq_d;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] changed, edge_det, clear_bits;

  // Next-state logic for synchronizer, debounce, edge capture and bus registers
  always_comb begin
    wr_en       = chipselect & ~write_n;
    rd_en       = chipselect & ~read_n;
    sync1_d     = in_port;
    sync2_d     = sync1_q;
    stable_d    = stable_q;
    primed_d    = primed_q;
    prime_cnt_d = prime_cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
    end

    if (!primed_q) begin
      // Third edge after release: adopt the synchronized lines as-is, no edges.
      prime_cnt_d = prime_cnt_q + 2'd1;
      if (prime_cnt_q == 2'd2) begin
        primed_d = 1'b1;
        stable_d = sync2_q;
      end else begin
        primed_d = 1'b0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if ((DEBOUNCE == 0) || (cnt_q[i] == CNT_MAX)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    changed = primed_q ? (stable_d ^ stable_q) : '0;
    case (EDGE_TYPE)
      0:       edge_det = changed & stable_d;
      1:       edge_det = changed & ~stable_d;
      default: edge_det = changed;
    endcase

    // A new edge overrides a simultaneous clear of the same bit.
    clear_bits = (wr_en && (address == 2'd3)) ? writedata : '0;
    edge_cap_d = (edge_cap_q & ~clear_bits) | edge_det;
    irq_mask_d = (wr_en && (address == 2'd2)) ? writedata : irq_mask_q;
    irq_d      = |(edge_cap_q & irq_mask_q);

    readdata_d = readdata_q;
    if (rd_en) begin
      case (address)
        2'd0:    readdata_d = stable_q;
        2'd2:    readdata_d = irq_mask_q;
        2'd3:    readdata_d = edge_cap_q;
        default: readdata_d = '0;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      edge_cap_q  <= '0;
      irq_mask_q  <= '0;
      readdata_q  <= '0;
      prime_cnt_q <= 2'd0;
      primed_q    <= 1'b0;
      irq_q       <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      edge_cap_q  <= edge_cap_d;
      irq_mask_q  <= irq_mask_d;
      readdata_q  <= readdata_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      irq_q       <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
